// File: rtl/mcctrl.sv
// Multi-cycle main control FSM for the RV32 core: fetch/decode/execute/memory/writeback sequencing.
// Latency: outputs are combinational from the state register; R=4, beq=3, lw=5, sw=4 cycles with no memory waits.
// Backpressure: mem_ready=0 holds FETCH, MEMREAD or MEMWRITE with the outputs unchanged; it is ignored elsewhere.
//
// Ports:
//   clk, reset (async, active-high)   opcode[6:0], zero, mem_ready      - control inputs
//   pcwrite, irwrite, adrsrc, memread, memwrite, regwrite              - datapath enables/selects
//   alusrca[1:0], alusrcb[1:0], aluop[1:0], resultsrc[1:0]             - mux selects, ALU decoder op
//   illegal (sticky trap), instret[31:0] (retired count), state[3:0]   - status / debug
module mcctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        irwrite,
    output logic        adrsrc,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  aluop,
    output logic [1:0]  resultsrc,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_TRAP     = 4'd9
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
            instret   <= 32'd0;
        end else begin
            cur_state <= nxt_state;
            if (retire) begin
                instret <= instret + 32'd1;
            end
        end
    end

    assign state = cur_state;

    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        pcwrite   = 1'b0;
        irwrite   = 1'b0;
        adrsrc    = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        resultsrc = 2'b00;
        illegal   = 1'b0;

        case (cur_state)
            S_FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                // PC+4 and IR load only on the cycle the fetch completes
                pcwrite   = mem_ready;
                irwrite   = mem_ready;
                if (mem_ready) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                // old PC + imm lands in ALUOut as the branch target
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_R:         nxt_state = S_EXECR;
                    OP_BR:        nxt_state = S_BEQ;
                    default:      nxt_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca   = 2'b10;
                alusrcb   = 2'b01;
                nxt_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                memread = 1'b1;
                if (mem_ready) nxt_state = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_EXECR: begin
                alusrca   = 2'b10;
                aluop     = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite  = 1'b1;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_BEQ: begin
                // ALUOut already holds the target; take it only when rs1 == rs2
                alusrca   = 2'b10;
                aluop     = 2'b01;
                pcwrite   = zero;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP: begin
                // absorbing state, so the flag stays set until reset
                illegal = 1'b1;
            end
            default: begin
                nxt_state = S_FETCH;
            end
        endcase

        if (reset) begin
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcctrl.sv
// Directed testbench for mcctrl: per-cycle expected control words are queued by the driver.
// Latency: the monitor compares each queued word at the falling edge of the same cycle.
// Backpressure: mem_ready wait cycles are part of the directed sequences.
module tb_mcctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pcwrite, irwrite, adrsrc, memread, memwrite, regwrite;
    logic [1:0]  alusrca, alusrcb, aluop, resultsrc;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state;

    mcctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .irwrite(irwrite), .adrsrc(adrsrc), .memread(memread),
        .memwrite(memwrite), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .resultsrc(resultsrc), .illegal(illegal), .instret(instret),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw, irw, adr, mrd, mwr, rgw;
        logic [1:0]  sa, sb, op, rs;
        logic        ill;
        logic [31:0] ic;
    } ctl_t;

    ctl_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc_no = 0;
    string  tag = "reset";

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4,
                           MX = 4'd5, ER = 4'd6, AW = 4'd7, BQ = 4'd8, TR = 4'd9;

    // Output table of each state as documented for the control unit.
    function automatic ctl_t expect_word(input logic [3:0] st, input logic mr, input logic z,
                                         input logic rst, input logic [31:0] ic);
        ctl_t e;
        e = '0;
        e.st = st;
        e.ic = ic;
        case (st)
            FE: begin e.mrd = 1'b1; e.sb = 2'b10; e.rs = 2'b10; e.pcw = mr; e.irw = mr; end
            DE: begin e.sa = 2'b01; e.sb = 2'b01; end
            MA: begin e.sa = 2'b10; e.sb = 2'b01; end
            MR: begin e.adr = 1'b1; e.mrd = 1'b1; end
            MW: begin e.rs = 2'b01; e.rgw = 1'b1; end
            MX: begin e.adr = 1'b1; e.mwr = 1'b1; end
            ER: begin e.sa = 2'b10; e.op = 2'b10; end
            AW: begin e.rgw = 1'b1; end
            BQ: begin e.sa = 2'b10; e.op = 2'b01; e.pcw = z; end
            TR: begin e.ill = 1'b1; end
            default: ;
        endcase
        if (rst) begin
            e.pcw = 1'b0; e.irw = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; e.rgw = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle: inputs change 1 time unit after the rising edge, expectation queued.
    task automatic cyc(input logic [3:0] st, input logic mr, input logic z, input logic [31:0] ic);
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(expect_word(st, mr, z, reset, ic));
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per queued cycle, sampled mid-cycle.
    always @(negedge clk) begin
        ctl_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{st: state, pcw: pcwrite, irw: irwrite, adr: adrsrc, mrd: memread,
                  mwr: memwrite, rgw: regwrite, sa: alusrca, sb: alusrcb, op: aluop,
                  rs: resultsrc, ill: illegal, ic: instret};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h, expected %h (state %0d vs %0d, instret %0d vs %0d)",
                         tag, cyc_no, a, e, a.st, e.st, a.ic, e.ic);
            end
            if (memread && memwrite) begin
                errors++;
                $display("FAIL %s cycle %0d: memread and memwrite both high", tag, cyc_no);
            end
            cyc_no++;
        end
    end

    task automatic run_r(input logic [31:0] ic);
        opcode = 7'b0110011;
        cyc(FE, 1, 0, ic); cyc(DE, 1, 0, ic); cyc(ER, 1, 0, ic); cyc(AW, 1, 0, ic);
    endtask

    initial begin
        reset = 1'b1; opcode = 7'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        // reset state with enables held low
        cyc(FE, 1, 0, 0);
        cyc(FE, 1, 0, 0);
        reset = 1'b0;

        tag = "rtype";
        run_r(0);

        tag = "lw_waits";
        opcode = 7'b0000011;
        cyc(FE, 0, 0, 1); cyc(FE, 0, 0, 1); cyc(FE, 1, 0, 1);
        cyc(DE, 0, 0, 1); cyc(MA, 0, 0, 1);
        cyc(MR, 0, 0, 1); cyc(MR, 0, 0, 1); cyc(MR, 0, 0, 1); cyc(MR, 1, 0, 1);
        cyc(MW, 0, 0, 1);

        tag = "beq_taken";
        opcode = 7'b1100011;
        cyc(FE, 1, 1, 2); cyc(DE, 1, 1, 2); cyc(BQ, 1, 1, 2);
        tag = "beq_not_taken";
        cyc(FE, 1, 0, 3); cyc(DE, 1, 0, 3); cyc(BQ, 0, 0, 3);

        tag = "sw";
        opcode = 7'b0100011;
        cyc(FE, 1, 0, 4); cyc(DE, 0, 0, 4); cyc(MA, 0, 0, 4);
        cyc(MX, 0, 0, 4); cyc(MX, 0, 1, 4); cyc(MX, 1, 0, 4);

        tag = "trap";
        opcode = 7'b0010011;
        cyc(FE, 1, 0, 5); cyc(DE, 1, 0, 5);
        for (int i = 0; i < 20; i++) cyc(TR, logic'(i[0]), logic'(i[1]), 5);

        tag = "trap_reset";
        reset = 1'b1;
        cyc(FE, 1, 0, 0);
        reset = 1'b0;

        tag = "seven_r";
        for (int i = 0; i < 7; i++) run_r(i);

        tag = "lw_abort";
        opcode = 7'b0000011;
        cyc(FE, 1, 0, 7); cyc(DE, 1, 0, 7); cyc(MA, 1, 0, 7); cyc(MR, 0, 0, 7);
        // asynchronous: checked before any further clock edge
        reset = 1'b1;
        cyc(FE, 1, 0, 0);
        reset = 1'b0;
        tag = "after_abort";
        cyc(FE, 1, 0, 0); cyc(DE, 1, 0, 0); cyc(MA, 1, 0, 0);
        cyc(MR, 1, 0, 0); cyc(MW, 1, 0, 0); cyc(FE, 0, 0, 1);

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
